stream_demux_ctrl: RTL and testbench
====================================

Name: stream_demux_ctrl

Overview:
- Packet-aware steering controller for an N-way output demux in the NoC/stream path.
- Takes one val/rdy stream whose first beat carries a destination select, and locks that destination for the whole packet (through the `last` beat).
- Routes beats through a one-entry output register to the selected output with per-output val/rdy; unselected outputs see zero data.
- Packets whose select is out of range are consumed and dropped, and counted.

Parameters:
- NUM_OUTPUTS, 4, number of destination ports (>=2).
- NUM_LOG_OUTPUTS, $clog2(NUM_OUTPUTS), select width.
- DATA_W, 256, beat width in bits.
- DROP_CNT_W, 16, width of drop counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- src_val  in  1  input beat valid.
- src_sel  in  NUM_LOG_OUTPUTS  destination; sampled only on a packet's first beat.
- src_data  in  DATA_W  beat payload.
- src_last  in  1  last beat of packet.
- src_rdy  out  1  input beat accepted when src_val & src_rdy.
- dst_val  out  NUM_OUTPUTS  per-output valid.
- dst_data  out  NUM_OUTPUTS x DATA_W  per-output payload; '0 on non-selected outputs.
- dst_last  out  NUM_OUTPUTS  per-output last; 0 on non-selected outputs.
- dst_rdy  in  NUM_OUTPUTS  per-output ready.
- drop_cnt  out  DROP_CNT_W  count of dropped packets, saturating.

Behaviour:
- Reset (async assert, sync deassert use): state=IDLE, out_val=0, out_sel=0, out_data=0, out_last=0, drop_cnt=0. All dst_val/dst_last/dst_data are 0.
- Output register:
  - Fields: out_val, out_sel, out_data, out_last.
  - dst_val[i] = out_val & (out_sel==i); dst_data[i] / dst_last[i] follow the same gating.
- can_load = ~out_val | dst_rdy[out_sel]. This allows a drain and a reload in the same cycle, giving full throughput of 1 beat/cycle.
- Latency: an accepted beat appears on dst one cycle after acceptance.
- src_rdy:
  - IDLE or LOCKED: src_rdy = can_load.
  - DROP: src_rdy = 1.
  - src_rdy never depends on src_val.
- State machine:
  - IDLE, accepted beat, src_sel < NUM_OUTPUTS: load the register with sel=src_sel and latch cur_sel=src_sel. If src_last, stay IDLE; else go to LOCKED.
  - IDLE, accepted beat, src_sel >= NUM_OUTPUTS: the beat is not loaded; drop_cnt increments (saturating at all-ones). If src_last, stay IDLE; else go to DROP.
  - LOCKED, accepted beat: load with sel=cur_sel; src_sel is ignored. If src_last, go to IDLE.
  - DROP, accepted beat: discard. If src_last, go to IDLE.
- When NUM_OUTPUTS is a power of two, the DROP state and drop_cnt increment are unreachable; drop_cnt stays 0.
- Output register hold rules:
  - Unchanged while out_val & ~dst_rdy[out_sel].
  - out_val clears on drain when no new beat is loaded.
  - Other fields may hold stale values while out_val=0, but dst_* stay gated to 0.
- Packets never interleave: a new packet's select is sampled only after the previous packet's last beat has been accepted.
- Reset mid-packet truncates the packet: no last is emitted and the register is flushed. Downstream handles the truncation.
- A stalled destination blocks all traffic (head-of-line blocking by design); no timeout.

Test Plan:
- Single packets: 3-beat packet sel=2 data A,B,C with dst_rdy all 1 -> dst_val[2] high for 3 consecutive cycles starting 1 cycle after the first accept. dst_last[2] only with C; all other dst_val/data are 0.
- Select lock: 4-beat packet first beat sel=1, later beats sel=3 -> all 4 beats exit port 1. Then a 1-beat packet sel=0 -> exits port 0 with last=1, state returns to IDLE.
- Backpressure: dst_rdy[0]=0 for 5 cycles mid-packet -> src_rdy=0 after one beat is buffered, dst_data[0] held stable, no beat lost or duplicated. Release -> 1 beat/cycle resumes.
- Drop (NUM_OUTPUTS=3): 2-beat packet sel=3 -> src_rdy=1 both beats, no dst_val asserted, drop_cnt=1. Following sel=0 packet is delivered normally. Force drop_cnt to 0xFFFF and drop another -> stays 0xFFFF.
- Reset mid-operation: assert rst_n=0 asynchronously mid-packet with out_val=1 -> dst_val immediately 0, drop_cnt=0. After release, a new sel=2 packet routes correctly with a fresh select.
- Random: random src_val/dst_rdy/sel/lengths for 10k beats -> scoreboard per-port in-order delivery, correct last marking, drop_cnt matches the number of invalid-select packets.

Source files
------------

// File: rtl/stream_demux_ctrl.sv
// Packet-aware steering controller for an N-way stream demux.
// Locks the first-beat select for the whole packet and drops packets with an out-of-range select.
module stream_demux_ctrl #(
    parameter int unsigned NUM_OUTPUTS     = 4,
    parameter int unsigned NUM_LOG_OUTPUTS = $clog2(NUM_OUTPUTS),
    parameter int unsigned DATA_W          = 256,
    parameter int unsigned DROP_CNT_W      = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                src_val,
    input  logic [NUM_LOG_OUTPUTS-1:0]          src_sel,
    input  logic [DATA_W-1:0]                   src_data,
    input  logic                                src_last,
    output logic                                src_rdy,
    output logic [NUM_OUTPUTS-1:0]              dst_val,
    output logic [NUM_OUTPUTS-1:0][DATA_W-1:0]  dst_data,
    output logic [NUM_OUTPUTS-1:0]              dst_last,
    input  logic [NUM_OUTPUTS-1:0]              dst_rdy,
    output logic [DROP_CNT_W-1:0]               drop_cnt
);

    localparam int unsigned SEL_CMP_W = NUM_LOG_OUTPUTS + 1;
    localparam logic [SEL_CMP_W-1:0] NUM_OUT_CMP = SEL_CMP_W'(NUM_OUTPUTS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCKED = 2'd1,
        ST_DROP   = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [NUM_LOG_OUTPUTS-1:0] r_cur_sel;
    logic                       r_out_val;
    logic [NUM_LOG_OUTPUTS-1:0] r_out_sel;
    logic [DATA_W-1:0]          r_out_data;
    logic                       r_out_last;
    logic [DROP_CNT_W-1:0]      r_drop_cnt;

    logic                       w_sel_rdy;
    logic                       w_can_load;
    logic                       w_sel_ok;
    logic                       w_accept;
    logic                       w_load;
    logic [NUM_LOG_OUTPUTS-1:0] w_load_sel;
    logic                       w_drop_inc;

    // Ready of the port currently held in the output register.
    always_comb begin
        w_sel_rdy = 1'b0;
        for (int i = 0; i < int'(NUM_OUTPUTS); i++) begin
            if (r_out_sel == NUM_LOG_OUTPUTS'(i)) begin
                w_sel_rdy = dst_rdy[i];
            end
        end
    end

    assign w_can_load = ~r_out_val | w_sel_rdy;
    assign w_sel_ok   = ({1'b0, src_sel} < NUM_OUT_CMP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_sel  = r_cur_sel;
        w_drop_inc  = 1'b0;
        src_rdy     = (r_state == ST_DROP) ? 1'b1 : w_can_load;
        w_accept    = src_val & src_rdy;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_sel_ok) begin
                        w_load     = 1'b1;
                        w_load_sel = src_sel;
                        if (!src_last) w_state_nxt = ST_LOCKED;
                    end else begin
                        w_drop_inc = 1'b1;
                        if (!src_last) w_state_nxt = ST_DROP;
                    end
                end
            end
            ST_LOCKED: begin
                if (w_accept) begin
                    w_load = 1'b1;
                    if (src_last) w_state_nxt = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (w_accept && src_last) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // One-entry output register: drain and reload may happen in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_val  <= 1'b0;
            r_out_sel  <= '0;
            r_out_data <= '0;
            r_out_last <= 1'b0;
            r_cur_sel  <= '0;
        end else begin
            if (w_load) begin
                r_out_val  <= 1'b1;
                r_out_sel  <= w_load_sel;
                r_out_data <= src_data;
                r_out_last <= src_last;
                r_cur_sel  <= w_load_sel;
            end else if (w_can_load) begin
                r_out_val <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (w_drop_inc && (r_drop_cnt != {DROP_CNT_W{1'b1}})) begin
            r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
        end
    end

    // Unselected outputs are gated to zero.
    always_comb begin
        dst_val  = '0;
        dst_last = '0;
        dst_data = '0;
        for (int i = 0; i < int'(NUM_OUTPUTS); i++) begin
            if (r_out_val && (r_out_sel == NUM_LOG_OUTPUTS'(i))) begin
                dst_val[i]  = 1'b1;
                dst_last[i] = r_out_last;
                dst_data[i] = r_out_data;
            end
        end
    end

    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_stream_demux_ctrl.sv
// Directed and randomized checks for stream_demux_ctrl with 3 outputs, so that one select code is invalid.
module tb_stream_demux_ctrl;

    localparam int unsigned NO   = 3;
    localparam int unsigned SW   = 2;
    localparam int unsigned DW   = 32;
    localparam int unsigned CW   = 2;
    localparam int          CYC_LIMIT = 60000;

    logic                    clk;
    logic                    rst_n;
    logic                    src_val;
    logic [SW-1:0]           src_sel;
    logic [DW-1:0]           src_data;
    logic                    src_last;
    logic                    src_rdy;
    logic [NO-1:0]           dst_val;
    logic [NO-1:0][DW-1:0]   dst_data;
    logic [NO-1:0]           dst_last;
    logic [NO-1:0]           dst_rdy;
    logic [CW-1:0]           drop_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    stream_demux_ctrl #(
        .NUM_OUTPUTS     (NO),
        .NUM_LOG_OUTPUTS (SW),
        .DATA_W          (DW),
        .DROP_CNT_W      (CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .src_val  (src_val),
        .src_sel  (src_sel),
        .src_data (src_data),
        .src_last (src_last),
        .src_rdy  (src_rdy),
        .dst_val  (dst_val),
        .dst_data (dst_data),
        .dst_last (dst_last),
        .dst_rdy  (dst_rdy),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [SW-1:0] s, input logic [DW-1:0] d, input logic l);
        src_val  = v;
        src_sel  = s;
        src_data = d;
        src_last = l;
    endtask

    // Reference model state for the random phase
    logic [DW:0] q [NO][$];
    int  m_port;
    bit  m_in;
    bit  m_drop;
    int  m_drops;
    int  m_beats;

    task automatic check_outputs();
        chk("onehot", 64'($countones(dst_val) <= 1), 64'd1);
        for (int i = 0; i < int'(NO); i++) begin
            if (dst_val[i]) begin
                if (q[i].size() == 0) begin
                    chk("rand_spurious", 64'(dst_val[i]), 64'd0);
                end else begin
                    chk("rand_beat", 64'({dst_last[i], dst_data[i]}), 64'(q[i][0]));
                    if (dst_rdy[i]) void'(q[i].pop_front());
                end
            end else begin
                chk("rand_gate", 64'({dst_last[i], dst_data[i]}), 64'd0);
            end
        end
    endtask

    initial begin
        int  cyc;
        bit  acc;
        bit  g_first;
        int  g_remain;
        logic [SW-1:0] g_sel;
        logic [DW-1:0] g_data;
        int  exp_drops;

        rst_n   = 1'b1;
        dst_rdy = '1;
        drive(1'b0, '0, '0, 1'b0);
        #2 rst_n = 1'b0;
        #3;
        chk("rst_dst_val", 64'(dst_val), 64'd0);
        chk("rst_dst_last", 64'(dst_last), 64'd0);
        chk("rst_dst_data", 64'(dst_data), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // 3-beat packet to port 2
        drive(1'b1, 2'd2, 32'hA, 1'b0);
        #1 chk("t1_rdy", 64'(src_rdy), 64'd1);
        tick();
        chk("t1_val_a", 64'(dst_val), 64'b100);
        chk("t1_data_a", 64'(dst_data[2]), 64'hA);
        chk("t1_last_a", 64'(dst_last), 64'd0);
        chk("t1_other_a", 64'({dst_data[1], dst_data[0]}), 64'd0);
        drive(1'b1, 2'd0, 32'hB, 1'b0);
        tick();
        chk("t1_val_b", 64'(dst_val), 64'b100);
        chk("t1_data_b", 64'(dst_data[2]), 64'hB);
        drive(1'b1, 2'd0, 32'hC, 1'b1);
        tick();
        chk("t1_val_c", 64'(dst_val), 64'b100);
        chk("t1_data_c", 64'(dst_data[2]), 64'hC);
        chk("t1_last_c", 64'(dst_last), 64'b100);
        drive(1'b0, '0, '0, 1'b0);
        tick();
        chk("t1_idle", 64'(dst_val), 64'd0);

        // Select lock: later beats carry sel=3 but stay on port 1
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, (k == 0) ? 2'd1 : 2'd3, 32'h100 + 32'(k), k == 3);
            if (k > 0) begin
                chk("t2_val", 64'(dst_val), 64'b010);
                chk("t2_data", 64'(dst_data[1]), 64'h100 + 64'(k - 1));
            end
            tick();
        end
        drive(1'b1, 2'd0, 32'h200, 1'b1);
        chk("t2_val_last", 64'(dst_val), 64'b010);
        chk("t2_data_last", 64'(dst_data[1]), 64'h103);
        chk("t2_last", 64'(dst_last), 64'b010);
        tick();
        chk("t2_p0_val", 64'(dst_val), 64'b001);
        chk("t2_p0_data", 64'(dst_data[0]), 64'h200);
        chk("t2_p0_last", 64'(dst_last), 64'b001);
        drive(1'b0, '0, '0, 1'b0);
        tick();
        chk("t2_idle", 64'(dst_val), 64'd0);

        // Backpressure on port 0
        drive(1'b1, 2'd0, 32'hD0, 1'b0);
        tick();
        chk("t3_d0", 64'(dst_data[0]), 64'hD0);
        dst_rdy = 3'b110;
        drive(1'b1, 2'd0, 32'hD1, 1'b0);
        #1 chk("t3_rdy_low", 64'(src_rdy), 64'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t3_hold_val", 64'(dst_val), 64'b001);
            chk("t3_hold_data", 64'(dst_data[0]), 64'hD0);
            chk("t3_hold_rdy", 64'(src_rdy), 64'd0);
        end
        dst_rdy = 3'b111;
        #1 chk("t3_rdy_rel", 64'(src_rdy), 64'd1);
        tick();
        chk("t3_d1", 64'(dst_data[0]), 64'hD1);
        drive(1'b1, 2'd0, 32'hD2, 1'b0);
        tick();
        chk("t3_d2", 64'(dst_data[0]), 64'hD2);
        drive(1'b1, 2'd0, 32'hD3, 1'b1);
        tick();
        chk("t3_d3", 64'(dst_data[0]), 64'hD3);
        chk("t3_d3_last", 64'(dst_last), 64'b001);
        drive(1'b0, '0, '0, 1'b0);
        tick();
        chk("t3_idle", 64'(dst_val), 64'd0);

        // Drop of an invalid-select packet, then saturation
        drive(1'b1, 2'd3, 32'hDEAD0001, 1'b0);
        #1 chk("t4_rdy0", 64'(src_rdy), 64'd1);
        tick();
        chk("t4_noval0", 64'(dst_val), 64'd0);
        chk("t4_cnt1", 64'(drop_cnt), 64'd1);
        drive(1'b1, 2'd0, 32'hDEAD0002, 1'b1);
        #1 chk("t4_rdy1", 64'(src_rdy), 64'd1);
        tick();
        chk("t4_noval1", 64'(dst_val), 64'd0);
        chk("t4_cnt1b", 64'(drop_cnt), 64'd1);
        drive(1'b1, 2'd0, 32'h300, 1'b1);
        tick();
        chk("t4_p0_val", 64'(dst_val), 64'b001);
        chk("t4_p0_data", 64'(dst_data[0]), 64'h300);
        for (int j = 0; j < 3; j++) begin
            drive(1'b1, 2'd3, 32'h400 + 32'(j), 1'b1);
            tick();
            chk("t4_sat_cnt", 64'(drop_cnt), (j == 0) ? 64'd2 : 64'd3);
            chk("t4_sat_noval", 64'(dst_val), 64'd0);
        end
        drive(1'b0, '0, '0, 1'b0);
        tick();

        // Asynchronous reset mid-packet
        drive(1'b1, 2'd1, 32'h500, 1'b0);
        tick();
        chk("t5_pre_val", 64'(dst_val), 64'b010);
        drive(1'b0, '0, '0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_val", 64'(dst_val), 64'd0);
        chk("t5_rst_cnt", 64'(drop_cnt), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        drive(1'b1, 2'd2, 32'h600, 1'b1);
        tick();
        chk("t5_new_val", 64'(dst_val), 64'b100);
        chk("t5_new_data", 64'(dst_data[2]), 64'h600);
        drive(1'b0, '0, '0, 1'b0);
        tick();

        // Random traffic against the scoreboard
        cyc = 0; acc = 1'b0; g_first = 1'b0; g_remain = 0; g_sel = '0; g_data = 32'h1000;
        m_port = 0; m_in = 1'b0; m_drop = 1'b0; m_drops = 0; m_beats = 0;
        while (cyc < CYC_LIMIT) begin
            if (acc) begin
                src_val  = 1'b0;
                g_remain = g_remain - 1;
                g_first  = 1'b0;
            end
            if (!src_val && g_remain == 0 && m_beats >= 10000) break;
            if (!src_val && $urandom_range(0, 3) != 0) begin
                if (g_remain == 0) begin
                    g_remain = int'($urandom_range(1, 4));
                    g_sel    = SW'($urandom_range(0, 3));
                    g_first  = 1'b1;
                end
                drive(1'b1, g_first ? g_sel : SW'($urandom_range(0, 3)), g_data, g_remain == 1);
                g_data = g_data + 32'd1;
            end
            for (int i = 0; i < int'(NO); i++) dst_rdy[i] = ($urandom_range(0, 3) != 0);
            #1;
            check_outputs();
            acc = src_val & src_rdy;
            if (acc) begin
                m_beats++;
                if (!m_in) begin
                    m_drop = ({1'b0, src_sel} >= 3'(NO));
                    m_port = int'(src_sel);
                    if (m_drop) m_drops++;
                end
                if (!m_drop) q[m_port].push_back({src_last, src_data});
                m_in = !src_last;
            end
            tick();
            cyc++;
        end
        chk("rand_in_budget", 64'(cyc < CYC_LIMIT), 64'd1);
        drive(1'b0, '0, '0, 1'b0);
        dst_rdy = '1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_outputs();
            tick();
        end
        chk("rand_q_empty", 64'(q[0].size() + q[1].size() + q[2].size()), 64'd0);
        exp_drops = (m_drops > 3) ? 3 : m_drops;
        chk("rand_drop_cnt", 64'(drop_cnt), 64'(exp_drops));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
